// File: rtl/mul_result_accumulator.sv
// Sums BLOCK_LEN consecutive multiplier products and presents each block total on a valid/ready port.
// Optional ACC_SATURATE_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module mul_result_accumulator #(
    parameter int unsigned BLOCK_LEN = 4,
    parameter int unsigned ACC_W     = 72
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             done,
    input  logic [63:0]                      result,
    input  logic                             clear,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 acc_out,
    output logic [$clog2(BLOCK_LEN+1)-1:0]   acc_count,
    output logic                             overflow,
    output logic                             lost
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               done_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_d;
    logic               lost_d;
    logic               valid_d;

    logic               capture_c;
    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;
    logic [ACC_W-1:0]   add_c;
    logic               last_c;

    // Product adder with carry tracking; saturation keeps all-ones for the rest of the block.
    always_comb begin
        capture_c = done & ~done_q;
        sum_c     = {1'b0, acc_out} + SUM_W'(result);
        carry_c   = sum_c[ACC_W];
`ifdef ACC_SATURATE_EN
        add_c     = (carry_c || overflow) ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
        add_c     = sum_c[ACC_W-1:0];
`endif
        last_c    = (acc_count == CNT_W'(BLOCK_LEN - 1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_out;
        count_d = acc_count;
        ovf_d   = overflow;
        lost_d  = lost;
        valid_d = out_valid;

        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            lost_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (capture_c) begin
                        acc_d   = add_c;
                        count_d = acc_count + CNT_W'(1);
                        ovf_d   = overflow | carry_c;
                        if (last_c) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (capture_c) begin
                            // Product arriving with the handshake opens the next block.
                            acc_d   = ACC_W'(result);
                            count_d = CNT_W'(1);
                            ovf_d   = 1'b0;
                            if (BLOCK_LEN == 1) begin
                                state_d = HOLD;
                                valid_d = 1'b1;
                            end else begin
                                state_d = ACCUM;
                                valid_d = 1'b0;
                            end
                        end else begin
                            state_d = ACCUM;
                            acc_d   = '0;
                            count_d = '0;
                            ovf_d   = 1'b0;
                            valid_d = 1'b0;
                        end
                    end else if (capture_c) begin
                        lost_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and registered outputs; done_q tracks done even during clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ACCUM;
            done_q    <= 1'b0;
            acc_out   <= '0;
            acc_count <= '0;
            overflow  <= 1'b0;
            lost      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done;
            acc_out   <= acc_d;
            acc_count <= count_d;
            overflow  <= ovf_d;
            lost      <= lost_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_mul_result_accumulator.sv
// Directed bench for mul_result_accumulator: default instance (4 x 72b) plus a 2 x 64b instance for overflow.
module tb_mul_result_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done = 1'b0;
    logic [63:0] result = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_valid, a_ovf, a_lost;
    logic [71:0] a_acc;
    logic [2:0]  a_cnt;
    logic        b_valid, b_ovf, b_lost;
    logic [63:0] b_acc;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_result_accumulator #(.BLOCK_LEN(4), .ACC_W(72)) dut_a (
        .clk(clk), .rst(rst), .done(done), .result(result), .clear(clear),
        .out_valid(a_valid), .out_ready(out_ready), .acc_out(a_acc),
        .acc_count(a_cnt), .overflow(a_ovf), .lost(a_lost)
    );

    mul_result_accumulator #(.BLOCK_LEN(2), .ACC_W(64)) dut_b (
        .clk(clk), .rst(rst), .done(done), .result(result), .clear(clear),
        .out_valid(b_valid), .out_ready(out_ready), .acc_out(b_acc),
        .acc_count(b_cnt), .overflow(b_ovf), .lost(b_lost)
    );

    // One done pulse; returns at the negedge where the capture is visible.
    task automatic cap(input logic [63:0] v);
        @(negedge clk); done = 1'b1; result = v;
        @(negedge clk); done = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", a_valid); end
        total++; if (a_acc !== 72'd0) begin bad++; $display("FAIL reset_acc got=%0h exp=0", a_acc); end
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0h exp=0", a_ovf); end
        total++; if (a_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%0h exp=0", a_lost); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic();
        cap(64'd36);
        total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=1", a_cnt); end
        total++; if (a_acc !== 72'd36) begin bad++; $display("FAIL basic_acc1 got=%0d exp=36", a_acc); end
        cap(64'd15);
        cap(64'd14);
        total++; if (a_acc !== 72'd65) begin bad++; $display("FAIL basic_acc3 got=%0d exp=65", a_acc); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL basic_valid3 got=%0h exp=0", a_valid); end
        cap(64'd16);
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h exp=1", a_valid); end
        total++; if (a_acc !== 72'd81) begin bad++; $display("FAIL basic_acc got=%0d exp=81", a_acc); end
        total++; if (a_cnt !== 3'd4) begin bad++; $display("FAIL basic_cnt got=%0d exp=4", a_cnt); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0h exp=0", a_ovf); end
        total++; if (a_lost !== 1'b0) begin bad++; $display("FAIL basic_lost got=%0h exp=0", a_lost); end
    endtask

    task automatic test_backpressure();
        cap(64'd60);
        repeat (2) @(negedge clk);
        total++; if (a_acc !== 72'd81) begin bad++; $display("FAIL bp_acc got=%0d exp=81", a_acc); end
        total++; if (a_cnt !== 3'd4) begin bad++; $display("FAIL bp_cnt got=%0d exp=4", a_cnt); end
        total++; if (a_lost !== 1'b1) begin bad++; $display("FAIL bp_lost got=%0h exp=1", a_lost); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0h exp=1", a_valid); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL hs_valid got=%0h exp=0", a_valid); end
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL hs_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_acc !== 72'd0) begin bad++; $display("FAIL hs_acc got=%0d exp=0", a_acc); end
        total++; if (a_lost !== 1'b1) begin bad++; $display("FAIL hs_lost got=%0h exp=1", a_lost); end
    endtask

    task automatic test_back_to_back();
        cap(64'd1); cap(64'd2); cap(64'd3); cap(64'd4);
        total++; if (a_acc !== 72'd10) begin bad++; $display("FAIL b2b_block got=%0d exp=10", a_acc); end
        @(negedge clk); out_ready = 1'b1; done = 1'b1; result = 64'd7;
        @(negedge clk); out_ready = 1'b0; done = 1'b0;
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%0h exp=0", a_valid); end
        total++; if (a_acc !== 72'd7) begin bad++; $display("FAIL b2b_acc got=%0d exp=7", a_acc); end
        total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", a_cnt); end
        total++; if (a_lost !== 1'b1) begin bad++; $display("FAIL b2b_lost got=%0h exp=1", a_lost); end
        pulse_clear();
        total++; if (a_lost !== 1'b0) begin bad++; $display("FAIL clr_lost got=%0h exp=0", a_lost); end
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", a_cnt); end
    endtask

    task automatic test_level_done();
        @(negedge clk); done = 1'b1; result = 64'd0;
        @(negedge clk); result = 64'd5;
        repeat (4) @(negedge clk);
        done = 1'b0;
        total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL level_cnt got=%0d exp=1", a_cnt); end
        total++; if (a_acc !== 72'd0) begin bad++; $display("FAIL level_acc got=%0d exp=0", a_acc); end
        pulse_clear();
    endtask

    task automatic test_clear_mid();
        cap(64'd6); cap(64'd9);
        total++; if (a_acc !== 72'd15) begin bad++; $display("FAIL clrm_pre got=%0d exp=15", a_acc); end
        @(negedge clk); clear = 1'b1; done = 1'b1; result = 64'd100;
        @(negedge clk); clear = 1'b0;
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL clrm_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_acc !== 72'd0) begin bad++; $display("FAIL clrm_acc got=%0d exp=0", a_acc); end
        @(negedge clk); done = 1'b0;
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL clrm_nocap got=%0d exp=0", a_cnt); end
        cap(64'd5); cap(64'd6); cap(64'd7); cap(64'd8);
        total++; if (a_acc !== 72'd26) begin bad++; $display("FAIL clrm_next got=%0d exp=26", a_acc); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL clrm_valid got=%0h exp=1", a_valid); end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        cap(64'd1); cap(64'd2); cap(64'd3); cap(64'd4); cap(64'd9);
        total++; if (a_lost !== 1'b1) begin bad++; $display("FAIL rstm_prelost got=%0h exp=1", a_lost); end
        #2 rst = 1'b0;
        #1;
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rstm_valid got=%0h exp=0", a_valid); end
        total++; if (a_acc !== 72'd0) begin bad++; $display("FAIL rstm_acc got=%0d exp=0", a_acc); end
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL rstm_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_lost !== 1'b0) begin bad++; $display("FAIL rstm_lost got=%0h exp=0", a_lost); end
        @(negedge clk); rst = 1'b1;
        cap(64'd6); cap(64'd9);
        total++; if (a_acc !== 72'd15) begin bad++; $display("FAIL rstm_after got=%0d exp=15", a_acc); end
        pulse_clear();
    endtask

    task automatic test_overflow();
        logic [63:0] exp_acc;
`ifdef ACC_SATURATE_EN
        exp_acc = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_acc = 64'd1;
`endif
        pulse_clear();
        cap(64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%0h exp=0", b_ovf); end
        cap(64'd2);
        total++; if (b_acc !== exp_acc) begin bad++; $display("FAIL ovf_acc got=%0h exp=%0h", b_acc, exp_acc); end
        total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", b_ovf); end
        total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0h exp=1", b_valid); end
        total++; if (b_cnt !== 2'd2) begin bad++; $display("FAIL ovf_cnt got=%0d exp=2", b_cnt); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_hs got=%0h exp=0", b_ovf); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL ovf_hsvalid got=%0h exp=0", b_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_level_done();
        test_clear_mid();
        test_reset_mid();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_result_accumulator.md
# mul_result_accumulator

Downstream consumer of the 32-bit multiplier's `done`/`result` outputs. It detects each completed product, sums `BLOCK_LEN` consecutive 64-bit products into a wide unsigned accumulator, and presents each block total on a valid/ready output port. It tracks overflow and products lost while the output is back-pressured.

## Interface
- `BLOCK_LEN`, default 4: number of products summed per output block; must be ≥1.
- `ACC_W`, default 72: accumulator width in bits; must be ≥64.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `done`  input  1  multiplier completion flag; may be held high for several cycles.
- `result`  input  64  multiplier product; valid whenever `done` is high.
- `clear`  input  1  synchronous flush of the current block and sticky flags.
- `out_valid`  output  1  block total available.
- `out_ready`  input  1  consumer accepts the total.
- `acc_out`  output  ACC_W  block sum; stable while `out_valid` is high.
- `acc_count`  output  $clog2(BLOCK_LEN+1)  products captured into the current block.
- `overflow`  output  1  the current or presented block overflowed `ACC_W`.
- `lost`  output  1  sticky: at least one product was discarded during HOLD.

## Operation
- Capture event: a rising edge of `done`, defined as `done`=1 this cycle and `done_q`=0, where `done_q` is the registered `done`. `result` is sampled in that cycle. A level held high yields exactly one capture.
- State ACCUM:
  - On a capture: `acc ← acc + result` (result zero-extended to `ACC_W`) and `acc_count` increments.
  - On the capture that makes `acc_count` equal `BLOCK_LEN`: go to HOLD and set `out_valid`=1.
- State HOLD:
  - `acc_out`, `acc_count` and `overflow` are frozen.
  - When `out_valid && out_ready`: return to ACCUM with `acc`=0, `acc_count`=0, `overflow`=0.
- Capture in the same cycle as the handshake: that product is the first of the next block. `acc ← result`, `acc_count`=1, and `overflow`=0. If `BLOCK_LEN`=1, stay in HOLD with the new total.
- Capture in HOLD without a handshake: the product is discarded and `lost`←1.
- Overflow: a carry out of bit `ACC_W-1` sets `overflow`. Default behaviour wraps modulo 2^`ACC_W`.
- `clear`:
  - Has priority over capture and handshake.
  - Zeroes `acc`, `acc_count`, `overflow` and `lost`, deasserts `out_valid`, and enters ACCUM.
  - `done_q` still updates, so a level already high is not re-captured.
- Reset mid-operation: everything returns to reset values immediately; any partial block is discarded.

## Timing
- Reset values: `out_valid`=0, `acc_out`=0, `acc_count`=0, `overflow`=0, `lost`=0, `done_q`=0, state ACCUM.
- Capture-to-visible latency is 1 cycle: `acc_out` and `acc_count` update on the edge that ends the capture cycle.
- `out_valid` rises on the edge that registers the `BLOCK_LEN`-th capture and falls on the edge after the handshake cycle.
- `acc_out` is a direct register output, with no combinational path from `result`.
- `out_valid` does not depend combinationally on `out_ready`.
- Maximum throughput: one capture every 2 cycles, because `done` must fall between products.

## Configuration
- `ACC_SATURATE_EN` defined: on overflow the accumulator clamps to all-ones and stays there for the rest of the block; `overflow` is set.
- `ACC_SATURATE_EN` undefined: the sum wraps modulo 2^`ACC_W`; `overflow` is set.

## Test plan
- **Basic block:** `BLOCK_LEN`=4, captures 36, 15, 14, 16 → `out_valid`=1 one cycle after the 4th capture, `acc_out`=81, `acc_count`=4, `overflow`=0, `lost`=0.
- **Level done:** `done` held high for 5 cycles with `result`=0 then 5 → exactly one capture; `acc_count`=1, `acc_out`=0.
- **Back-pressure:** hold `out_ready`=0 for 4 cycles after block 81 and issue a capture of 60 in that window → `acc_out` stays 81 and `lost`=1. Then `out_ready`=1 → handshake, `acc_count`=0, `lost` still 1 until `clear`.
- **Simultaneous handshake and capture:** capture of 7 in the handshake cycle → next cycle `out_valid`=0, `acc_out`=7, `acc_count`=1.
- **Overflow:** `ACC_W`=64, `BLOCK_LEN`=2, captures 0xFFFF_FFFF_FFFF_FFFF then 2:
  - without the macro → `acc_out`=1, `overflow`=1;
  - with `ACC_SATURATE_EN` → `acc_out`=0xFFFF_FFFF_FFFF_FFFF, `overflow`=1.
- **Reset and clear mid-block:** after 2 captures (6, 9), pulse `rst` low → all outputs 0 asynchronously. Repeat with `clear`=1 for one cycle → same result on the next edge, and the following block sums correctly from 0.
